// File: rtl/spi_txn_queue.sv
// spi_txn_queue: feeds an SPI master from a host-written TX FIFO, one transfer
// per word, and collects the words the master returns into an RX FIFO.
// A watchdog aborts any transfer the master does not complete in time.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for enable, a queued word, RX space and an idle master
// LAUNCH    | start_tx high for this single cycle; watchdog cleared
// WAIT_DONE | watchdog counting; waiting for master_irq
// STORE     | holding register pushed into the RX FIFO; done high
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   enable                          permits new launches
//   wr_valid/wr_ready/wr_data       host write into TX FIFO
//   rd_valid/rd_ready/rd_data       host read from RX FIFO (show-ahead)
//   tx_level, rx_level              FIFO occupancies
//   done                            one-cycle pulse per word stored in RX
//   timeout_err, err_clr            sticky watchdog flag and its clear
//   start_tx, tx_data               launch pulse and word to the master
//   master_busy, master_irq,
//   master_rx_data                  status and returned word from the master
module spi_txn_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         wr_valid,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH):0]       tx_level,
  output logic [$clog2(DEPTH):0]       rx_level,
  output logic                         done,
  output logic                         timeout_err,
  input  logic                         err_clr,
  output logic                         start_tx,
  output logic [DATA_WIDTH-1:0]        tx_data,
  input  logic                         master_busy,
  input  logic                         master_irq,
  input  logic [DATA_WIDTH-1:0]        master_rx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, STORE} state_t;

  state_t                state;
  logic [23:0]           watchdog;
  logic [DATA_WIDTH-1:0] hold;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]         tx_wptr, tx_rptr;
  logic [LW-1:0]         tx_cnt;
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]         rx_wptr, rx_rptr;
  logic [LW-1:0]         rx_cnt;

  logic tx_push, tx_pop, rx_push, rx_pop, launch;

  assign wr_ready = (tx_cnt != LW'(DEPTH));
  assign rd_valid = (rx_cnt != '0);
  // Gated so rd_data reads zero whenever the RX FIFO is empty (incl. reset).
  assign rd_data  = rd_valid ? rx_mem[rx_rptr] : '0;
  assign tx_level = tx_cnt;
  assign rx_level = rx_cnt;

  // Launch only with RX space in hand, so STORE never meets a full RX FIFO.
  assign launch  = (state == IDLE) && enable && (tx_cnt != '0) &&
                   (rx_cnt != LW'(DEPTH)) && !master_busy;
  assign tx_push = wr_valid && wr_ready;
  assign tx_pop  = launch;
  assign rx_push = (state == STORE);
  assign rx_pop  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= wr_data;
    if (rx_push) rx_mem[rx_wptr] <= hold;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      watchdog    <= '0;
      hold        <= '0;
      tx_data     <= '0;
      start_tx    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start_tx <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            tx_data  <= tx_mem[tx_rptr];
            start_tx <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          watchdog <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          watchdog <= watchdog + 1'b1;
          // Completion beats expiry when both land in the same cycle.
          if (master_irq) begin
            hold  <= master_rx_data;
            done  <= 1'b1;
            state <= STORE;
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        STORE:   state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed last so a clear overrides a same-cycle set.
      if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_txn_queue.sv
// Testbench for spi_txn_queue: directed stimulus with a behavioural SPI
// master, scoreboard queues for launched and returned words, and a
// cycle-level occupancy model for both FIFOs.
module tb_spi_txn_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 20;
  localparam logic [31:0] KEY = 32'hB791_5977;   // master returns tx ^ KEY

  logic          clk = 1'b0;
  logic          rst, enable, wr_valid, wr_ready, rd_valid, rd_ready;
  logic          done, timeout_err, err_clr, start_tx, master_busy, master_irq;
  logic [DW-1:0] wr_data, rd_data, tx_data, master_rx_data;
  logic [3:0]    tx_level, rx_level;

  always #5 clk = ~clk;

  spi_txn_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .tx_level(tx_level), .rx_level(rx_level), .done(done),
    .timeout_err(timeout_err), .err_clr(err_clr),
    .start_tx(start_tx), .tx_data(tx_data),
    .master_busy(master_busy), .master_irq(master_irq),
    .master_rx_data(master_rx_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_launch = 0;
  int n_done   = 0;
  logic [31:0] exp_tx[$];
  logic [31:0] exp_rx[$];
  logic master_hang = 1'b0;
  logic force_irq   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Behavioural master: busy for a few cycles, then a one-cycle irq.
  initial begin
    master_busy    = 1'b0;
    master_irq     = 1'b0;
    master_rx_data = '0;
    forever begin
      @(negedge clk);
      if (force_irq) begin
        master_rx_data = 32'hDEAD_BEEF;
        master_irq     = 1'b1;
        @(negedge clk);
        master_irq     = 1'b0;
      end else if (start_tx && !master_hang && !rst) begin
        master_busy = 1'b1;
        repeat (3) @(negedge clk);
        master_rx_data = tx_data ^ KEY;
        master_irq     = 1'b1;
        @(negedge clk);
        master_irq  = 1'b0;
        master_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: launches and host reads.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_tx) begin
          n_launch++;
          if (exp_tx.size() == 0) bound_fail("launch_unexpected");
          else chk("launch_tx_data", tx_data, exp_tx.pop_front());
        end
        if (done) n_done++;
        if (rd_valid && rd_ready) begin
          if (exp_rx.size() == 0) bound_fail("read_unexpected");
          else chk("rd_data", rd_data, exp_rx.pop_front());
        end
      end
    end
  end

  // Occupancy model for both FIFOs, independent of the DUT counters.
  int   mt, mr;
  logic tpush_p, rpush_p, rpop_p;
  initial begin
    mt = 0; mr = 0; tpush_p = 1'b0; rpush_p = 1'b0; rpop_p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mt = 0; mr = 0; tpush_p = 1'b0; rpush_p = 1'b0; rpop_p = 1'b0;
      end else begin
        mt = mt + int'(tpush_p) - int'(start_tx);
        mr = mr + int'(rpush_p) - int'(rpop_p);
        chk("tx_level", 32'(tx_level), 32'(mt));
        chk("rx_level", 32'(rx_level), 32'(mr));
        chk("wr_ready", 32'(wr_ready), 32'(mt != DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(mr != 0));
        tpush_p = wr_valid && wr_ready;
        rpush_p = done;
        rpop_p  = rd_valid && rd_ready;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_ready"},    32'(wr_ready),    32'd1);
    chk({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
    chk({tag, "_rd_data"},     rd_data,          32'd0);
    chk({tag, "_tx_level"},    32'(tx_level),    32'd0);
    chk({tag, "_rx_level"},    32'(rx_level),    32'd0);
    chk({tag, "_done"},        32'(done),        32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_start_tx"},    32'(start_tx),    32'd0);
    chk({tag, "_tx_data"},     tx_data,          32'd0);
  endtask

  task automatic write_word(input logic [31:0] w, input logic expect_rx);
    int g = 0;
    while (!wr_ready && g < 300) begin
      tick;
      g++;
    end
    if (g >= 300) bound_fail("wr_ready_wait");
    exp_tx.push_back(w);
    if (expect_rx) exp_rx.push_back(w ^ KEY);
    wr_valid = 1'b1;
    wr_data  = w;
    tick;
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    rd_ready = 1'b1;
    while ((exp_rx.size() != 0 || rx_level != 0 || tx_level != 0) && g < 600) begin
      tick;
      g++;
    end
    if (g >= 600) bound_fail(name);
    rd_ready = 1'b0;
    tick;
  endtask

  int g, base_l, base_d;

  initial begin
    rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_ready = 1'b0; err_clr = 1'b0;
    repeat (2) tick;
    check_reset_vals("reset");
    rst = 1'b0;
    tick;

    // Single word: launch two edges after acceptance, then done, then rd_valid.
    enable = 1'b1;
    exp_tx.push_back(32'hA5A5_0F0F);
    exp_rx.push_back(32'h1234_5678);
    wr_valid = 1'b1;
    wr_data  = 32'hA5A5_0F0F;
    tick;
    wr_valid = 1'b0;
    chk("single_start_early", 32'(start_tx), 32'd0);
    tick;
    chk("single_start", 32'(start_tx), 32'd1);
    chk("single_tx_data", tx_data, 32'hA5A5_0F0F);
    g = 0;
    while (!done && g < 20) begin tick; g++; end
    if (g >= 20) bound_fail("single_done_wait");
    chk("single_no_bypass", 32'(rd_valid), 32'd0);
    tick;
    chk("single_rd_valid", 32'(rd_valid), 32'd1);
    chk("single_rd_data", rd_data, 32'h1234_5678);
    chk("single_rx_level", 32'(rx_level), 32'd1);
    chk("single_tx_data_held", tx_data, 32'hA5A5_0F0F);
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    chk("single_rd_empty", 32'(rd_valid), 32'd0);

    // Fill with enable low: 9th word refused.
    enable = 1'b0;
    base_l = n_launch;
    for (int i = 0; i < 9; i++) begin
      chk("fill_wr_ready", 32'(wr_ready), 32'(i < DEPTH));
      if (i < DEPTH) begin
        exp_tx.push_back(32'h1000_0000 + 32'(i));
        exp_rx.push_back((32'h1000_0000 + 32'(i)) ^ KEY);
      end
      wr_valid = 1'b1;
      wr_data  = 32'h1000_0000 + 32'(i);
      tick;
    end
    wr_valid = 1'b0;
    chk("fill_tx_level", 32'(tx_level), 32'd8);
    chk("fill_no_launch", 32'(n_launch - base_l), 32'd0);
    enable = 1'b1;
    g = 0;
    while (rx_level != 4'd8 && g < 300) begin tick; g++; end
    if (g >= 300) bound_fail("fill_rx_wait");
    chk("fill_launches", 32'(n_launch - base_l), 32'd8);
    chk("fill_tx_empty", 32'(tx_level), 32'd0);
    drain("fill_drain");

    // RX full stall: exactly 8 launches, one more per popped word.
    base_l = n_launch;
    for (int i = 0; i < 10; i++) write_word(32'h2000_0000 + 32'(i * 3), 1'b1);
    g = 0;
    while (rx_level != 4'd8 && g < 300) begin tick; g++; end
    if (g >= 300) bound_fail("stall_rx_wait");
    repeat (40) tick;
    chk("stall_launches", 32'(n_launch - base_l), 32'd8);
    chk("stall_tx_level", 32'(tx_level), 32'd2);
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    repeat (40) tick;
    chk("stall_one_more", 32'(n_launch - base_l), 32'd9);
    chk("stall_rx_full_again", 32'(rx_level), 32'd8);
    chk("stall_tx_left", 32'(tx_level), 32'd1);
    drain("stall_drain");

    // Timeout: hung master, expiry visible in cycle TO+1 after LAUNCH.
    master_hang = 1'b1;
    base_d = n_done;
    exp_tx.push_back(32'h3000_0001);
    exp_tx.push_back(32'h3000_0002);
    exp_rx.push_back(32'h3000_0002 ^ KEY);
    wr_valid = 1'b1;
    wr_data  = 32'h3000_0001;
    tick;
    wr_data  = 32'h3000_0002;
    tick;
    wr_valid = 1'b0;
    g = 0;
    while (!start_tx && g < 10) begin tick; g++; end
    if (g >= 10) bound_fail("timeout_launch_wait");
    for (int k = 1; k <= TO + 1; k++) begin
      tick;
      if (k == 5) master_hang = 1'b0;
      if (k == TO) chk("timeout_not_yet", 32'(timeout_err), 32'd0);
    end
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_no_done", 32'(n_done - base_d), 32'd0);
    chk("timeout_rx_unchanged", 32'(rx_level), 32'd0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("timeout_err_clr", 32'(timeout_err), 32'd0);
    drain("timeout_drain");
    chk("timeout_next_done", 32'(n_done - base_d), 32'd1);

    // Streaming across pointer wrap with host always reading.
    base_d   = n_done;
    rd_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) write_word(32'h4000_0000 ^ 32'(i * 32'h0101_0101), 1'b1);
    drain("stream_drain");
    chk("stream_done_count", 32'(n_done - base_d), 32'(3 * DEPTH));

    // Reset mid-WAIT_DONE with 3 words queued; late irq ignored.
    master_hang = 1'b1;
    for (int i = 0; i < 4; i++) write_word(32'h5000_0000 + 32'(i), 1'b0);
    repeat (2) tick;
    chk("pre_reset_tx_level", 32'(tx_level), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    exp_tx.delete();
    exp_rx.delete();
    base_l = n_launch;
    base_d = n_done;
    tick;
    rst = 1'b0;
    tick;
    force_irq = 1'b1;
    tick;
    force_irq = 1'b0;
    repeat (6) tick;
    chk("late_irq_no_done", 32'(n_done - base_d), 32'd0);
    chk("late_irq_no_launch", 32'(n_launch - base_l), 32'd0);
    chk("late_irq_rx_level", 32'(rx_level), 32'd0);
    chk("late_irq_rd_valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
